sweep_sequencer: RTL and testbench
==================================

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 Parameter: CYCLES_PER_MS, default 100000, clock cycles per millisecond at 100 MHz.
REQ-002 Parameter: DEPTH, default 8, number of segment-table entries; address width is 3.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-004 Ports SHALL be, as name / direction / width / meaning:
- clk  in  1  clock
- rst  in  1  async active-high reset
- wr_en  in  1  table write strobe
- wr_addr  in  3  table entry index
- wr_data  in  68  entry: [67:52] dwell_ms, [51:32] base_freq, [31:30] sweep_mode, [29:13] sweep_range, [12:0] sweep_speed
- start  in  1  begin sequence at entry 0
- stop  in  1  abort sequence
- loop_en  in  1  restart at entry 0 after last_idx
- last_idx  in  3  index of final entry
- base_freq  out  20  Hz to sweep datapath
- sweep_mode  out  2  00 none, 01 linear, 10 sinusoidal
- sweep_range  out  17  Hz
- sweep_speed  out  13  Hz/us
- seg_idx  out  3  active entry index
- seg_strobe  out  1  one-cycle pulse on each new segment applied
- busy  out  1  sequence running
- done  out  1  one-cycle pulse on normal completion

Function
REQ-005 The table SHALL be DEPTH x 68-bit registers; when wr_en is high, wr_data SHALL be written to wr_addr at the clock edge, in any state.
REQ-006 The FSM SHALL have three states: IDLE, LOAD and DWELL.
REQ-007 In IDLE, start=1 with stop=0 SHALL set seg_idx=0 and go to LOAD; start SHALL be ignored in LOAD and DWELL.
REQ-008 LOAD SHALL last 1 cycle: it reads entry seg_idx, registers the outputs, pulses seg_strobe and enters DWELL on the next edge.
REQ-009 seg_strobe SHALL be high in the first DWELL cycle, i.e. 2 cycles after the start edge for entry 0.
REQ-010 At LOAD, a same-cycle write to the entry being read SHALL NOT affect the loaded value; the old contents SHALL be used.
REQ-011 At LOAD, base_freq SHALL be clamped: values <1000 become 1000, values >999000 become 999000.
REQ-012 At LOAD, sweep_mode 11 SHALL be output as 00.
REQ-013 At LOAD, dwell_ms=0 SHALL be treated as 1.
REQ-014 In DWELL, a prescaler 0..CYCLES_PER_MS-1 and a 16-bit ms counter SHALL run; both SHALL be cleared on entry to DWELL.
REQ-015 DWELL SHALL last exactly dwell_ms*CYCLES_PER_MS cycles, so consecutive seg_strobe pulses are dwell_ms*CYCLES_PER_MS+1 cycles apart.
REQ-016 At the end of DWELL, if seg_idx != last_idx, seg_idx SHALL increment and the FSM SHALL go to LOAD.
REQ-017 At the end of DWELL, if seg_idx == last_idx and loop_en=1, seg_idx SHALL wrap to 0 and the FSM SHALL go to LOAD.
REQ-018 At the end of DWELL, if seg_idx == last_idx and loop_en=0, the FSM SHALL pulse done for 1 cycle, go to IDLE and force sweep_mode=00; the other outputs SHALL hold.
REQ-019 loop_en and last_idx SHALL be sampled at each DWELL end only.
REQ-020 If last_idx changes below the current seg_idx, seg_idx SHALL increment with 3-bit wrap until it equals last_idx.
REQ-021 stop=1 in any state SHALL force IDLE on the next edge, set sweep_mode=00, and deassert busy; done SHALL NOT pulse.
REQ-022 stop SHALL have priority over start and over a DWELL end in the same cycle.
REQ-023 busy SHALL be 1 in LOAD and DWELL and 0 in IDLE, registered alongside the state.
REQ-024 seg_strobe and done SHALL never be high in the same cycle.

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE, and the outputs SHALL be: base_freq=100000, sweep_mode=00, sweep_range=0, sweep_speed=0, seg_idx=0, seg_strobe=0, busy=0, done=0.
REQ-026 While rst=1, the prescaler, the ms counter and all table entries SHALL be cleared to 0.
REQ-027 rst asserted mid-DWELL SHALL take effect immediately; no done pulse SHALL occur.

Verification (CYCLES_PER_MS=10)
REQ-028 Two-entry run: entry0 {dwell 2, 50000 Hz, mode 01, range 1000, speed 5}, entry1 {dwell 1, 200000 Hz, mode 10}, last_idx=1, loop_en=0, start -> strobe at start+2 with base_freq 50000, strobe at +23 with 200000, done at +33 with sweep_mode 00 and busy 0.
REQ-029 Clamp: entry base_freq 500 and 1000000 -> outputs 1000 and 999000; mode 11 -> 00; dwell 0 -> strobes 11 cycles apart.
REQ-030 Loop: last_idx=2, loop_en=1 -> seg_idx sequence 0,1,2,0,1 with no done pulse; clearing loop_en during entry 2 -> done after entry 2.
REQ-031 Stop: stop asserted with start, and stop mid-DWELL of entry 1 -> IDLE next edge, sweep_mode 00, busy 0, no done, subsequent start restarts at entry 0.
REQ-032 Write hazard: write entry 1 during its LOAD cycle -> old value applied; the new value is applied on the next pass.
REQ-033 Async reset mid-DWELL -> all outputs at reset values within the same cycle, table entries read back 0.

Source files
------------

// File: rtl/sweep_sequencer.sv
// Segment-table sweep sequencer: steps through up to DEPTH programmed segments,
// applying each segment's sweep settings for dwell_ms milliseconds.
module sweep_sequencer #(
    parameter int unsigned CYCLES_PER_MS = 100000,
    parameter int unsigned DEPTH         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [67:0] wr_data,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [2:0]  last_idx,
    output logic [19:0] base_freq,
    output logic [1:0]  sweep_mode,
    output logic [16:0] sweep_range,
    output logic [12:0] sweep_speed,
    output logic [2:0]  seg_idx,
    output logic        seg_strobe,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);
    localparam logic [19:0] FREQ_MIN = 20'd1000;
    localparam logic [19:0] FREQ_MAX = 20'd999000;

    typedef enum logic [1:0] {StIdle, StLoad, StDwell} state_e;

    state_e        state_q, state_d;
    logic [67:0]   table_q [DEPTH];
    logic [19:0]   base_freq_q, base_freq_d;
    logic [1:0]    sweep_mode_q, sweep_mode_d;
    logic [16:0]   sweep_range_q, sweep_range_d;
    logic [12:0]   sweep_speed_q, sweep_speed_d;
    logic [2:0]    seg_idx_q, seg_idx_d;
    logic          seg_strobe_q, seg_strobe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_q, ms_d;
    logic [15:0]   dwell_q, dwell_d;

    logic [67:0] entry;
    logic [19:0] entry_freq;
    logic        dwell_end;

    // Registered table read: a write landing on the same edge as LOAD is not seen.
    assign entry      = table_q[seg_idx_q];
    assign entry_freq = entry[51:32];
    assign dwell_end  = (presc_q == PRESC_LAST) && (ms_q == dwell_q - 16'd1);

    always_comb begin
        state_d       = state_q;
        base_freq_d   = base_freq_q;
        sweep_mode_d  = sweep_mode_q;
        sweep_range_d = sweep_range_q;
        sweep_speed_d = sweep_speed_q;
        seg_idx_d     = seg_idx_q;
        seg_strobe_d  = 1'b0;
        done_d        = 1'b0;
        presc_d       = presc_q;
        ms_d          = ms_q;
        dwell_d       = dwell_q;

        if (stop) begin
            state_d      = StIdle;
            sweep_mode_d = 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        seg_idx_d = 3'd0;
                        state_d   = StLoad;
                    end
                end
                StLoad: begin
                    if (entry_freq < FREQ_MIN) begin
                        base_freq_d = FREQ_MIN;
                    end else if (entry_freq > FREQ_MAX) begin
                        base_freq_d = FREQ_MAX;
                    end else begin
                        base_freq_d = entry_freq;
                    end
                    sweep_mode_d  = (entry[31:30] == 2'b11) ? 2'b00 : entry[31:30];
                    sweep_range_d = entry[29:13];
                    sweep_speed_d = entry[12:0];
                    dwell_d       = (entry[67:52] == 16'd0) ? 16'd1 : entry[67:52];
                    presc_d       = '0;
                    ms_d          = 16'd0;
                    seg_strobe_d  = 1'b1;
                    state_d       = StDwell;
                end
                StDwell: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        ms_d    = ms_q + 16'd1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (dwell_end) begin
                        if (seg_idx_q != last_idx) begin
                            seg_idx_d = seg_idx_q + 3'd1;
                            state_d   = StLoad;
                        end else if (loop_en) begin
                            seg_idx_d = 3'd0;
                            state_d   = StLoad;
                        end else begin
                            done_d       = 1'b1;
                            sweep_mode_d = 2'b00;
                            state_d      = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            base_freq_q   <= 20'd100000;
            sweep_mode_q  <= 2'b00;
            sweep_range_q <= '0;
            sweep_speed_q <= '0;
            seg_idx_q     <= 3'd0;
            seg_strobe_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            presc_q       <= '0;
            ms_q          <= 16'd0;
            dwell_q       <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            base_freq_q   <= base_freq_d;
            sweep_mode_q  <= sweep_mode_d;
            sweep_range_q <= sweep_range_d;
            sweep_speed_q <= sweep_speed_d;
            seg_idx_q     <= seg_idx_d;
            seg_strobe_q  <= seg_strobe_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            presc_q       <= presc_d;
            ms_q          <= ms_d;
            dwell_q       <= dwell_d;
            if (wr_en && ({29'd0, wr_addr} < DEPTH)) begin
                table_q[wr_addr] <= wr_data;
            end
        end
    end

    assign base_freq   = base_freq_q;
    assign sweep_mode  = sweep_mode_q;
    assign sweep_range = sweep_range_q;
    assign sweep_speed = sweep_speed_q;
    assign seg_idx     = seg_idx_q;
    assign seg_strobe  = seg_strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer with CYCLES_PER_MS=10; cycle 0 is the cycle start is driven.
module tb_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [67:0] wr_data;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [2:0]  last_idx;
    logic [19:0] base_freq;
    logic [1:0]  sweep_mode;
    logic [16:0] sweep_range;
    logic [12:0] sweep_speed;
    logic [2:0]  seg_idx;
    logic        seg_strobe;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int seen;

    sweep_sequencer #(
        .CYCLES_PER_MS(10),
        .DEPTH        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .last_idx   (last_idx),
        .base_freq  (base_freq),
        .sweep_mode (sweep_mode),
        .sweep_range(sweep_range),
        .sweep_speed(sweep_speed),
        .seg_idx    (seg_idx),
        .seg_strobe (seg_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (done && seg_strobe) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        cur += n;
    endtask

    task automatic go_to(input int c);
        step(c - cur);
    endtask

    function automatic logic [67:0] ent(input int dwell, input int base, input int mode,
                                        input int range, input int speed);
        logic [67:0] e;
        e = {dwell[15:0], base[19:0], mode[1:0], range[16:0], speed[12:0]};
        return e;
    endfunction

    task automatic wr(input int addr, input logic [67:0] data);
        wr_en   = 1'b1;
        wr_addr = addr[2:0];
        wr_data = data;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        cur   = 0;
        step(1);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_freq"}, 32'(base_freq), 100000);
        check({tag, "_mode"}, 32'(sweep_mode), 0);
        check({tag, "_range"}, 32'(sweep_range), 0);
        check({tag, "_speed"}, 32'(sweep_speed), 0);
        check({tag, "_idx"}, 32'(seg_idx), 0);
        check({tag, "_strobe"}, 32'(seg_strobe), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_idx = 3'd0;
        #1;
        check_reset_outputs("rst");
        step(2);
        rst = 1'b0;
        step(1);

        // Two-entry run
        wr(0, ent(2, 50000, 1, 1000, 5));
        wr(1, ent(1, 200000, 2, 0, 0));
        last_idx = 3'd1;
        kick();
        check("run_load_busy", 32'(busy), 1);
        check("run_load_strobe", 32'(seg_strobe), 0);
        go_to(2);
        check("run_s0_strobe", 32'(seg_strobe), 1);
        check("run_s0_freq", 32'(base_freq), 50000);
        check("run_s0_mode", 32'(sweep_mode), 1);
        check("run_s0_range", 32'(sweep_range), 1000);
        check("run_s0_speed", 32'(sweep_speed), 5);
        check("run_s0_idx", 32'(seg_idx), 0);
        go_to(3);
        check("run_strobe_pulse", 32'(seg_strobe), 0);
        go_to(22);
        check("run_pre_s1", 32'(seg_strobe), 0);
        go_to(23);
        check("run_s1_strobe", 32'(seg_strobe), 1);
        check("run_s1_freq", 32'(base_freq), 200000);
        check("run_s1_mode", 32'(sweep_mode), 2);
        check("run_s1_idx", 32'(seg_idx), 1);
        go_to(32);
        check("run_pre_done", 32'(done), 0);
        check("run_pre_busy", 32'(busy), 1);
        go_to(33);
        check("run_done", 32'(done), 1);
        check("run_done_mode", 32'(sweep_mode), 0);
        check("run_done_busy", 32'(busy), 0);
        check("run_done_freq_hold", 32'(base_freq), 200000);
        go_to(34);
        check("run_done_pulse", 32'(done), 0);

        // Clamping, mode 11 and zero dwell
        wr(0, ent(0, 500, 3, 7, 9));
        wr(1, ent(1, 1000000, 1, 0, 0));
        kick();
        go_to(2);
        check("clamp_lo_freq", 32'(base_freq), 1000);
        check("clamp_mode11", 32'(sweep_mode), 0);
        go_to(12);
        check("clamp_dw0_gap", 32'(seg_strobe), 0);
        go_to(13);
        check("clamp_dw0_strobe", 32'(seg_strobe), 1);
        check("clamp_hi_freq", 32'(base_freq), 999000);
        go_to(23);
        check("clamp_done", 32'(done), 1);
        step(2);

        // Looping over three entries
        wr(0, ent(1, 10000, 1, 0, 0));
        wr(1, ent(1, 20000, 1, 0, 0));
        wr(2, ent(1, 30000, 1, 0, 0));
        last_idx = 3'd2;
        loop_en  = 1'b1;
        seen = done_cnt;
        kick();
        for (int k = 0; k < 5; k++) begin
            go_to(2 + 11 * k);
            check("loop_strobe", 32'(seg_strobe), 1);
            check("loop_idx", 32'(seg_idx), 32'(k % 3));
        end
        check("loop_no_done", 32'(done_cnt), 32'(seen));
        go_to(57);
        check("loop_last_idx", 32'(seg_idx), 2);
        loop_en = 1'b0;
        go_to(67);
        check("loop_exit_done", 32'(done), 1);
        check("loop_exit_idx", 32'(seg_idx), 2);
        step(2);

        // Stop handling
        seen = done_cnt;
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check("stop_with_start", 32'(busy), 0);
        last_idx = 3'd1;
        kick();
        go_to(13);
        check("stop_s1_idx", 32'(seg_idx), 1);
        go_to(16);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_mode", 32'(sweep_mode), 0);
        check("stop_no_done", 32'(done_cnt), 32'(seen));
        kick();
        go_to(2);
        check("stop_restart_idx", 32'(seg_idx), 0);
        check("stop_restart_freq", 32'(base_freq), 10000);
        stop = 1'b1;
        step(1);
        stop = 1'b0;

        // Write to entry 1 during its LOAD cycle
        wr(0, ent(1, 10000, 1, 0, 0));
        wr(1, ent(1, 20000, 1, 0, 0));
        loop_en = 1'b1;
        kick();
        go_to(12);
        wr_en = 1'b1;
        wr_addr = 3'd1;
        wr_data = ent(1, 30000, 2, 0, 0);
        step(1);
        wr_en = 1'b0;
        check("haz_old_freq", 32'(base_freq), 20000);
        check("haz_old_mode", 32'(sweep_mode), 1);
        go_to(35);
        check("haz_new_idx", 32'(seg_idx), 1);
        check("haz_new_freq", 32'(base_freq), 30000);
        check("haz_new_mode", 32'(sweep_mode), 2);

        // Async reset mid-dwell
        go_to(38);
        seen = done_cnt;
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        step(2);
        rst = 1'b0;
        check("arst_no_done", 32'(done_cnt), 32'(seen));
        loop_en  = 1'b0;
        last_idx = 3'd0;
        kick();
        go_to(2);
        check("arst_tbl_freq", 32'(base_freq), 1000);
        check("arst_tbl_mode", 32'(sweep_mode), 0);
        check("arst_tbl_range", 32'(sweep_range), 0);
        check("arst_tbl_speed", 32'(sweep_speed), 0);
        go_to(12);
        check("arst_tbl_done", 32'(done), 1);
        step(2);

        check("strobe_done_overlap", 32'(both_cnt), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
